int16alu_issue: RTL and testbench
=================================

// Module: int16alu_issue
// PURPOSE
//  Issue/writeback controller that drives int16alu from the initiator side. Buffers decoded
//  ALU instructions in a small FIFO, issues them under the ALU valid_in/busy contract, and
//  tracks the 2-cycle multiplier path (MUL/MULI/FMA). Tags ALU results with a destination
//  register and returns them to the register-file writeback port. Sits between decode and int16alu.
// PARAMETERS
//  DEPTH   4   instruction FIFO entries (power of 2, >=2)
//  DST_W   4   destination register tag width
// PORTS
//  clk          in   1      clock
//  rst          in   1      async active-high reset (top ties int16alu.rst_n = ~rst)
//  in_valid     in   1      decode offers an instruction
//  in_ready     out  1      FIFO not full
//  in_op        in   5      ISA opcode (gpu_define.v OP_*)
//  in_cmp_mode  in   2      COMP_EQ/NE/LT/LE
//  in_pred      in   1      predicate value for SELP
//  in_a/in_b/in_c in 16 ea. rA, rB/imm16, rC operands
//  in_dst       in   DST_W  destination tag
//  in_wb_en     in   1      result is written back
//  flush        in   1      drop all queued (not yet issued) entries
//  alu_op/alu_cmp_mode/alu_pred_val/alu_op_a/b/c  out 5/2/1/16/16/16  FIFO head fields
//  alu_valid_in out  1      issue strobe to int16alu
//  alu_busy     in   1      int16alu busy
//  alu_valid_out in  1      int16alu result valid
//  alu_result   in   16     int16alu result
//  wb_valid     out  1      writeback strobe (registered)
//  wb_dst       out  DST_W  writeback tag
//  wb_data      out  16     writeback data
//  wb_is_pred   out  1      result came from SETP (write predicate file, not GPR)
//  idle         out  1      FIFO empty and state ISSUE
//  proto_err    out  1      sticky ALU-contract violation flag
// BEHAVIOUR
//  Reset: FIFO empty, state ISSUE, in_ready=1, alu_valid_in=0, wb_*=0, idle=1, proto_err=0.
//  FIFO: push on in_valid&in_ready; registered, no bypass (earliest issue = accept+1).
//   in_ready = !full; push and pop in one cycle permitted when not full.
//  alu_* data outs = head fields when non-empty, else 0; qualified only by alu_valid_in.
//  FSM states ISSUE, MWAIT1, MWAIT2:
//   ISSUE: alu_valid_in = !empty & !flush; head popped on issue.
//    single-cycle op -> stay ISSUE; result in same cycle captured at edge -> wb_valid issue+1.
//    mult op (MUL/MULI/FMA) -> MWAIT1; latch dst/wb_en/is_pred into inflight regs.
//   MWAIT1 -> MWAIT2 -> ISSUE unconditionally; alu_valid_in=0 in both.
//    MWAIT2: alu_valid_out expected; captured -> wb_valid at issue+3. Next issue at issue+3
//    (never in MWAIT2: ALU result mux/addsub would collide with mult_done).
//  Throughput: 1 instr/cycle for single-cycle ops; mult ops occupy 3 cycles.
//  Writeback: wb_valid = captured valid & wb_en; wb_is_pred = (op==OP_SETP); wb_data=alu_result
//   zero-extended as delivered. wb_valid is single-cycle; wb_dst/data hold until next wb.
//  flush: clears FIFO same edge, beats a concurrent push (push dropped), suppresses issue that
//   cycle; in-flight mult still completes and writes back.
//  proto_err set when: alu_busy=1 while alu_valid_in=1; alu_valid_out=1 outside (single issue
//   cycle | MWAIT2); alu_valid_out=0 in MWAIT2 or in a single-cycle issue cycle. Cleared by rst only.
//  Reset mid-operation: all state dropped, in-flight result discarded, no wb_valid.
// STRUCTURE
//  gpu_define.v (shared): OP_* opcodes, COMP_* modes; add ALU_MULT_LAT=2 and an
//   is_mult_op function/macro used by both int16alu and this block.
//  Sub-module: issue_fifo (sync FIFO, DEPTH x {op,cmp,pred,a,b,c,dst,wb_en}); FSM+wb in top.
// TESTING (bench instantiates int16alu with rst_n=~rst)
//  ADD a=3 b=4 dst=2 -> alu_valid_in 1 cycle after accept; wb_valid next cycle, dst=2, data=7.
//  4 back-to-back ADDI (dst 0..3) -> issue every cycle, 4 consecutive wb_valid, in order, no gaps.
//  MUL 5*6 dst=1 then ADD 1+1 dst=9 queued -> wb 30@issue+3, ADD issued issue+3, wb 2 next; proto_err=0.
//  FMA a=-2 b=7 c=20 -> wb_data=0x0006 after 3 cycles; SETP LT a=-1 b=0 -> wb_data=1, wb_is_pred=1.
//  Fill FIFO to DEPTH -> in_ready=0, extra in_valid ignored; flush with MUL in MWAIT1 -> queue empty,
//   MUL still writes back, no other wb_valid.
//  Assert rst in MWAIT1 -> no wb_valid, idle=1 next cycle; force alu_busy=1 at issue -> proto_err=1.

Source files
------------

// File: rtl/int16alu_issue_pkg.sv
// Shared ALU opcode/compare encodings, issue-side request record and mult-op classifier.
package int16alu_issue_pkg;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_ADDI = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_MUL  = 5'h03;
    localparam logic [4:0] OP_MULI = 5'h04;
    localparam logic [4:0] OP_FMA  = 5'h05;
    localparam logic [4:0] OP_SETP = 5'h06;
    localparam logic [4:0] OP_SELP = 5'h07;

    localparam logic [1:0] COMP_EQ = 2'd0;
    localparam logic [1:0] COMP_NE = 2'd1;
    localparam logic [1:0] COMP_LT = 2'd2;
    localparam logic [1:0] COMP_LE = 2'd3;

    localparam int unsigned ALU_MULT_LAT = 2;

    typedef struct packed {
        logic [4:0]  op;
        logic [1:0]  cmp;
        logic        pred;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
    } alu_req_t;

    function automatic logic is_mult_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_MULI) || (op == OP_FMA);
    endfunction

endpackage

// File: rtl/int16alu_issue_fifo.sv
// Synchronous instruction FIFO: registered, no bypass; flush clears and beats a concurrent push.
module int16alu_issue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push & ~o_full & ~i_flush;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/int16alu_issue.sv
// Issue/writeback controller in front of int16alu: queues decoded ops, issues under the
// valid_in/busy contract, waits out the 2-cycle multiplier and returns tagged results.
module int16alu_issue
    import int16alu_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DST_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [1:0]       in_cmp_mode,
    input  logic             in_pred,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [15:0]      in_c,
    input  logic [DST_W-1:0] in_dst,
    input  logic             in_wb_en,
    input  logic             flush,
    output logic [4:0]       alu_op,
    output logic [1:0]       alu_cmp_mode,
    output logic             alu_pred_val,
    output logic [15:0]      alu_op_a,
    output logic [15:0]      alu_op_b,
    output logic [15:0]      alu_op_c,
    output logic             alu_valid_in,
    input  logic             alu_busy,
    input  logic             alu_valid_out,
    input  logic [15:0]      alu_result,
    output logic             wb_valid,
    output logic [DST_W-1:0] wb_dst,
    output logic [15:0]      wb_data,
    output logic             wb_is_pred,
    output logic             idle,
    output logic             proto_err
);
    typedef enum logic [1:0] {ST_ISSUE, ST_MWAIT1, ST_MWAIT2} state_t;

    localparam int unsigned ENT_W = $bits(alu_req_t) + DST_W + 1;

    alu_req_t         w_in_req;
    alu_req_t         w_head_req;
    logic [ENT_W-1:0] w_wr_ent;
    logic [ENT_W-1:0] w_head_ent;
    logic [DST_W-1:0] w_head_dst;
    logic             w_head_wb_en;
    logic             w_empty;
    logic             w_full;
    logic             w_issue;
    logic             w_head_mult;
    logic             w_vout_exp;
    logic             w_err;

    state_t           r_state;
    logic [DST_W-1:0] r_if_dst;
    logic             r_if_wb_en;
    logic             r_if_is_pred;
    logic             r_wb_valid;
    logic [DST_W-1:0] r_wb_dst;
    logic [15:0]      r_wb_data;
    logic             r_wb_is_pred;
    logic             r_proto_err;

    assign w_in_req = '{op: in_op, cmp: in_cmp_mode, pred: in_pred, a: in_a, b: in_b, c: in_c};
    assign w_wr_ent = {in_dst, in_wb_en, w_in_req};
    assign {w_head_dst, w_head_wb_en, w_head_req} = w_head_ent;

    int16alu_issue_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (in_valid & in_ready),
        .i_pop   (w_issue),
        .i_data  (w_wr_ent),
        .o_data  (w_head_ent),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign in_ready     = ~w_full;
    assign w_issue      = (r_state == ST_ISSUE) & ~w_empty & ~flush;
    assign w_head_mult  = is_mult_op(w_head_req.op);
    assign alu_valid_in = w_issue;
    assign alu_op       = w_empty ? '0 : w_head_req.op;
    assign alu_cmp_mode = w_empty ? '0 : w_head_req.cmp;
    assign alu_pred_val = w_empty ? 1'b0 : w_head_req.pred;
    assign alu_op_a     = w_empty ? '0 : w_head_req.a;
    assign alu_op_b     = w_empty ? '0 : w_head_req.b;
    assign alu_op_c     = w_empty ? '0 : w_head_req.c;

    // A result is due exactly in a single-cycle issue cycle or in MWAIT2, never elsewhere.
    assign w_vout_exp = (w_issue & ~w_head_mult) | (r_state == ST_MWAIT2);
    assign w_err      = (alu_busy & w_issue) | (alu_valid_out != w_vout_exp);

    assign idle       = w_empty & (r_state == ST_ISSUE);
    assign wb_valid   = r_wb_valid;
    assign wb_dst     = r_wb_dst;
    assign wb_data    = r_wb_data;
    assign wb_is_pred = r_wb_is_pred;
    assign proto_err  = r_proto_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_ISSUE;
            r_if_dst     <= '0;
            r_if_wb_en   <= 1'b0;
            r_if_is_pred <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_dst     <= '0;
            r_wb_data    <= '0;
            r_wb_is_pred <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            if (w_err) r_proto_err <= 1'b1;
            case (r_state)
                ST_ISSUE: begin
                    if (w_issue) begin
                        if (w_head_mult) begin
                            r_state      <= ST_MWAIT1;
                            r_if_dst     <= w_head_dst;
                            r_if_wb_en   <= w_head_wb_en;
                            r_if_is_pred <= (w_head_req.op == OP_SETP);
                        end else if (alu_valid_out & w_head_wb_en) begin
                            r_wb_valid   <= 1'b1;
                            r_wb_dst     <= w_head_dst;
                            r_wb_data    <= alu_result;
                            r_wb_is_pred <= (w_head_req.op == OP_SETP);
                        end
                    end
                end
                ST_MWAIT1: r_state <= ST_MWAIT2;
                ST_MWAIT2: begin
                    r_state <= ST_ISSUE;
                    if (alu_valid_out & r_if_wb_en) begin
                        r_wb_valid   <= 1'b1;
                        r_wb_dst     <= r_if_dst;
                        r_wb_data    <= alu_result;
                        r_wb_is_pred <= r_if_is_pred;
                    end
                end
                default: r_state <= ST_ISSUE;
            endcase
        end
    end

endmodule

// File: tb/tb_int16alu_issue.sv
// Directed bench for int16alu_issue with a behavioural int16alu (1-cycle ops, 2-stage multiplier).
module tb_int16alu_issue;
    import int16alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0;
    logic [1:0]  in_cmp_mode = '0;
    logic        in_pred = 1'b0;
    logic [15:0] in_a = '0, in_b = '0, in_c = '0;
    logic [3:0]  in_dst = '0;
    logic        in_wb_en = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  alu_op;
    logic [1:0]  alu_cmp_mode;
    logic        alu_pred_val;
    logic [15:0] alu_op_a, alu_op_b, alu_op_c;
    logic        alu_valid_in;
    logic        alu_busy;
    logic        alu_valid_out;
    logic [15:0] alu_result;
    logic        wb_valid;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;
    logic        wb_is_pred;
    logic        idle;
    logic        proto_err;
    logic        tb_busy = 1'b0;

    always #5 clk = ~clk;

    int16alu_issue #(.DEPTH(4), .DST_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_cmp_mode(in_cmp_mode),
        .in_pred(in_pred), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_dst(in_dst),
        .in_wb_en(in_wb_en), .flush(flush),
        .alu_op(alu_op), .alu_cmp_mode(alu_cmp_mode), .alu_pred_val(alu_pred_val),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_c(alu_op_c),
        .alu_valid_in(alu_valid_in), .alu_busy(alu_busy), .alu_valid_out(alu_valid_out),
        .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data), .wb_is_pred(wb_is_pred),
        .idle(idle), .proto_err(proto_err)
    );

    // Behavioural int16alu (rst_n = ~rst)
    logic        m_mult;
    logic [15:0] m_comb;
    logic        s1v, s2v;
    logic [15:0] s1r, s2r;

    assign m_mult = (alu_op == OP_MUL) || (alu_op == OP_MULI) || (alu_op == OP_FMA);

    always_comb begin
        m_comb = '0;
        case (alu_op)
            OP_ADD, OP_ADDI: m_comb = alu_op_a + alu_op_b;
            OP_SUB:          m_comb = alu_op_a - alu_op_b;
            OP_SELP:         m_comb = alu_pred_val ? alu_op_a : alu_op_b;
            OP_SETP: begin
                case (alu_cmp_mode)
                    COMP_EQ: m_comb = {15'd0, alu_op_a == alu_op_b};
                    COMP_NE: m_comb = {15'd0, alu_op_a != alu_op_b};
                    COMP_LT: m_comb = {15'd0, $signed(alu_op_a) < $signed(alu_op_b)};
                    default: m_comb = {15'd0, $signed(alu_op_a) <= $signed(alu_op_b)};
                endcase
            end
            default: m_comb = '0;
        endcase
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s1v <= 1'b0;
            s2v <= 1'b0;
            s1r <= '0;
            s2r <= '0;
        end else begin
            s1v <= alu_valid_in & m_mult;
            s1r <= (alu_op == OP_FMA) ? (alu_op_a * alu_op_b + alu_op_c) : (alu_op_a * alu_op_b);
            s2v <= s1v;
            s2r <= s1r;
        end
    end

    assign alu_valid_out = (alu_valid_in & ~m_mult) | s2v;
    assign alu_result    = s2v ? s2r : m_comb;
    assign alu_busy      = s1v | s2v | tb_busy;

    // Bench bookkeeping
    typedef struct {
        int          c;
        logic [3:0]  dst;
        logic [15:0] data;
        logic        pred;
    } wb_t;

    typedef struct {
        logic [4:0]  op;
        logic [1:0]  cmp;
        logic        pred;
        logic [15:0] a, b, c;
        logic [3:0]  dst;
        logic        wb_en;
        logic [15:0] exp_data;
        logic        exp_pred;
        int          exp_lat;
    } vec_t;

    int  n_checks = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  base = 0;
    wb_t wq[$];
    int  iq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        wb_t e;
        @(negedge clk);
        cyc++;
        if (wb_valid) begin
            e.c = cyc; e.dst = wb_dst; e.data = wb_data; e.pred = wb_is_pred;
            wq.push_back(e);
        end
        if (alu_valid_in) iq.push_back(cyc);
    endtask

    task automatic drive(input logic [4:0] op, input logic [1:0] cm, input logic pr,
                         input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [3:0] dst, input logic wbe);
        in_valid = 1'b1; in_op = op; in_cmp_mode = cm; in_pred = pr;
        in_a = a; in_b = b; in_c = c; in_dst = dst; in_wb_en = wbe;
    endtask

    task automatic chk_wb(input string nm, input int idx, input int c, input logic [3:0] dst,
                          input logic [15:0] data);
        if (idx < wq.size()) begin
            chk({nm, "_cyc"}, wq[idx].c - base, c);
            chk({nm, "_dst"}, wq[idx].dst, dst);
            chk({nm, "_data"}, wq[idx].data, data);
        end
    endtask

    localparam int NV = 13;
    vec_t vt[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{OP_ADD,  COMP_EQ, 1'b0, 16'd3,    16'd4,    16'd0,  4'd2, 1'b1, 16'd7,    1'b0, 1};
        vt[1]  = '{OP_SUB,  COMP_EQ, 1'b0, 16'd3,    16'd5,    16'd0,  4'd5, 1'b1, 16'hFFFE, 1'b0, 1};
        vt[2]  = '{OP_ADDI, COMP_EQ, 1'b0, 16'h7FFF, 16'd1,    16'd0,  4'd6, 1'b1, 16'h8000, 1'b0, 1};
        vt[3]  = '{OP_MUL,  COMP_EQ, 1'b0, 16'd5,    16'd6,    16'd0,  4'd1, 1'b1, 16'd30,   1'b0, 3};
        vt[4]  = '{OP_MULI, COMP_EQ, 1'b0, 16'h0100, 16'h0100, 16'd0,  4'd8, 1'b1, 16'h0000, 1'b0, 3};
        vt[5]  = '{OP_FMA,  COMP_EQ, 1'b0, 16'hFFFE, 16'd7,    16'd20, 4'd3, 1'b1, 16'h0006, 1'b0, 3};
        vt[6]  = '{OP_SETP, COMP_LT, 1'b0, 16'hFFFF, 16'd0,    16'd0,  4'd4, 1'b1, 16'd1,    1'b1, 1};
        vt[7]  = '{OP_SETP, COMP_EQ, 1'b0, 16'd5,    16'd6,    16'd0,  4'd7, 1'b1, 16'd0,    1'b1, 1};
        vt[8]  = '{OP_SETP, COMP_LE, 1'b0, 16'd7,    16'd7,    16'd0,  4'd9, 1'b1, 16'd1,    1'b1, 1};
        vt[9]  = '{OP_SETP, COMP_NE, 1'b0, 16'd7,    16'd7,    16'd0,  4'hA, 1'b1, 16'd0,    1'b1, 1};
        vt[10] = '{OP_SELP, COMP_EQ, 1'b1, 16'h1111, 16'h2222, 16'd0,  4'hB, 1'b1, 16'h1111, 1'b0, 1};
        vt[11] = '{OP_SELP, COMP_EQ, 1'b0, 16'h1111, 16'h2222, 16'd0,  4'hC, 1'b1, 16'h2222, 1'b0, 1};
        vt[12] = '{OP_ADD,  COMP_EQ, 1'b0, 16'd9,    16'd9,    16'd0,  4'hD, 1'b0, 16'd0,    1'b0, 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_valid_in", alu_valid_in, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_dst", wb_dst, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_idle", idle, 1);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_alu_op_a", alu_op_a, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_idle", idle, 1);

        // Single-instruction vectors
        for (int i = 0; i < NV; i++) begin
            wq.delete(); iq.delete();
            tick(); base = cyc;
            drive(vt[i].op, vt[i].cmp, vt[i].pred, vt[i].a, vt[i].b, vt[i].c, vt[i].dst, vt[i].wb_en);
            tick(); in_valid = 1'b0;
            repeat (6) tick();
            chk($sformatf("v%0d_issues", i), iq.size(), 1);
            if (iq.size() > 0) chk($sformatf("v%0d_issue_at", i), iq[0] - base, 1);
            if (vt[i].exp_lat == 0) begin
                chk($sformatf("v%0d_no_wb", i), wq.size(), 0);
            end else begin
                chk($sformatf("v%0d_wb_count", i), wq.size(), 1);
                chk_wb($sformatf("v%0d", i), 0, 1 + vt[i].exp_lat, vt[i].dst, vt[i].exp_data);
                if (wq.size() > 0) chk($sformatf("v%0d_is_pred", i), wq[0].pred, vt[i].exp_pred);
            end
            chk($sformatf("v%0d_idle", i), idle, 1);
        end

        // Four back-to-back ADDI: issue every cycle, contiguous in-order writebacks
        wq.delete(); iq.delete();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 0) base = cyc;
            if (k < 4) drive(OP_ADDI, COMP_EQ, 1'b0, 16'(k * 10), 16'd1, 16'd0, 4'(k), 1'b1);
            else in_valid = 1'b0;
        end
        chk("b2b_issues", iq.size(), 4);
        chk("b2b_wb_count", wq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < iq.size()) chk($sformatf("b2b_issue%0d", k), iq[k] - base, k + 1);
            chk_wb($sformatf("b2b_wb%0d", k), k, k + 2, 4'(k), 16'(k * 10 + 1));
        end

        // MUL followed by a queued ADD: ADD waits until issue+3
        wq.delete(); iq.delete();
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k == 0) base = cyc;
            if (k == 0) drive(OP_MUL, COMP_EQ, 1'b0, 16'd5, 16'd6, 16'd0, 4'd1, 1'b1);
            else if (k == 1) drive(OP_ADD, COMP_EQ, 1'b0, 16'd1, 16'd1, 16'd0, 4'd9, 1'b1);
            else in_valid = 1'b0;
        end
        chk("mq_issues", iq.size(), 2);
        if (iq.size() > 1) begin
            chk("mq_issue_mul", iq[0] - base, 1);
            chk("mq_issue_add", iq[1] - base, 4);
        end
        chk("mq_wb_count", wq.size(), 2);
        chk_wb("mq_wb_mul", 0, 4, 4'd1, 16'd30);
        chk_wb("mq_wb_add", 1, 5, 4'd9, 16'd2);
        chk("mq_proto_err", proto_err, 0);

        // Fill to full behind MULs, then flush while a MUL sits in MWAIT1
        wq.delete(); iq.delete();
        for (int k = 0; k < 14; k++) begin
            tick();
            if (k == 0) base = cyc;
            if (k == 6) chk("fill_full_ready_k6", in_ready, 0);
            if (k == 7) chk("fill_full_ready_k7", in_ready, 0);
            if (k == 9) chk("flush_ready", in_ready, 1);
            if (k == 10) chk("flush_idle", idle, 1);
            flush = (k == 8);
            if (k <= 8) drive(OP_MUL, COMP_EQ, 1'b0, 16'(k + 2), 16'd3, 16'd0, 4'(k), 1'b1);
            else in_valid = 1'b0;
        end
        flush = 1'b0;
        chk("flush_issues", iq.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < iq.size()) chk($sformatf("flush_issue%0d", k), iq[k] - base, 3 * k + 1);
            chk_wb($sformatf("flush_wb%0d", k), k, 3 * k + 4, 4'(k), 16'((k + 2) * 3));
        end
        chk("flush_wb_count", wq.size(), 3);

        // Reset while a MUL is in MWAIT1: result discarded
        wq.delete(); iq.delete();
        tick(); base = cyc;
        drive(OP_MUL, COMP_EQ, 1'b0, 16'd5, 16'd6, 16'd0, 4'd7, 1'b1);
        tick(); in_valid = 1'b0;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rstmid_idle", idle, 1);
        chk("rstmid_wb_valid", wb_valid, 0);
        repeat (5) tick();
        chk("rstmid_no_wb", wq.size(), 0);
        chk("rstmid_proto_err", proto_err, 0);

        // alu_busy high during an issue cycle raises a sticky proto_err
        tick();
        drive(OP_ADD, COMP_EQ, 1'b0, 16'd1, 16'd2, 16'd0, 4'd3, 1'b1);
        tick(); in_valid = 1'b0;
        chk("busy_pre_err", proto_err, 0);
        chk("busy_issue_now", alu_valid_in, 1);
        tb_busy = 1'b1;
        tick(); tb_busy = 1'b0;
        chk("busy_proto_err", proto_err, 1);
        repeat (3) tick();
        chk("busy_sticky", proto_err, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
